// File: rtl/add_sub_arbiter_pkg.sv
// add_sub_arbiter_pkg
//   Shared definitions for the two-requester add/sub arbiter:
//   FSM state encoding and the default datapath width.
package add_sub_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/add_sub_arbiter_if.sv
// add_sub_arbiter_if
//   Bundles the two requester handshakes and the response channel.
//   slave  : the arbiter side (accepts requests, produces responses)
//   master : the requesters/consumer side
//   req{0,1}_valid/ready/a/b/m : request channels (m: 0 = a+b, 1 = a-b)
//   rsp_valid/ready/id/s/co    : response channel
interface add_sub_arbiter_if import add_sub_arbiter_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_m;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_m;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_s;
    logic             rsp_co;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_m,
        input  req1_valid, req1_a, req1_b, req1_m,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_s, rsp_co
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_m,
        output req1_valid, req1_a, req1_b, req1_m,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_s, rsp_co
    );
endinterface

// File: rtl/add_sub_arbiter_add_sub.sv
// add_sub
//   Combinational WIDTH-bit adder/subtractor.
//   a, b : operands
//   M    : 0 = a+b, 1 = a+~b+1 (a-b)
//   s    : result mod 2^WIDTH
//   co   : carry out of the top bit (for subtract: 1 = no borrow)
module add_sub import add_sub_arbiter_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             M,
    output logic [WIDTH-1:0] s,
    output logic             co
);
    logic [WIDTH-1:0] b_eff;

    // Subtract is add of the one's complement with carry-in 1.
    assign b_eff   = b ^ {WIDTH{M}};
    assign {co, s} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, M};
endmodule

// File: rtl/add_sub_arbiter.sv
// add_sub_arbiter
//   Round-robin arbiter giving two requesters access to one shared add_sub
//   datapath. IDLE grants and latches operands, EXEC registers the result,
//   RESP holds the response until the consumer takes it.
//   clk : clock (rising edge)
//   rst : asynchronous active-high reset
//   bus : add_sub_arbiter_if.slave (request and response channels)
module add_sub_arbiter import add_sub_arbiter_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    add_sub_arbiter_if.slave   bus
);
    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             op_m_q, op_m_d;
    logic             op_id_q, op_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_s_q, rsp_s_d;
    logic             rsp_co_q, rsp_co_d;

    logic             grant;
    logic             grant_id;
    logic             rsp_fire;
    logic [WIDTH-1:0] sum_s;
    logic             sum_co;

    // Contention goes to prio; a lone requester wins outright.
    assign grant_id = (bus.req0_valid && bus.req1_valid) ? prio_q : bus.req1_valid;
    // Ready is combinational, so gate it with rst to keep it low during reset.
    assign grant    = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid) && !rst;
    assign rsp_fire = rsp_valid_q && bus.rsp_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: at most one ready, only in the granting IDLE cycle
    always_comb begin
        bus.req0_ready = grant && !grant_id;
        bus.req1_ready = grant &&  grant_id;
    end

    // Operand latch, round-robin pointer and response register
    always_comb begin
        prio_d      = prio_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_m_d      = op_m_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_s_d     = rsp_s_q;
        rsp_co_d    = rsp_co_q;
        if (grant) begin
            op_a_d  = grant_id ? bus.req1_a : bus.req0_a;
            op_b_d  = grant_id ? bus.req1_b : bus.req0_b;
            op_m_d  = grant_id ? bus.req1_m : bus.req0_m;
            op_id_d = grant_id;
            prio_d  = !grant_id;
        end
        if (state_q == EXEC) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = op_id_q;
            rsp_s_d     = sum_s;
            rsp_co_d    = sum_co;
        end
        if (state_q == RESP && rsp_fire) rsp_valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q      <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_m_q      <= 1'b0;
            op_id_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_s_q     <= '0;
            rsp_co_q    <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_m_q      <= op_m_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_s_q     <= rsp_s_d;
            rsp_co_q    <= rsp_co_d;
        end
    end

    add_sub #(.WIDTH(WIDTH)) u_add_sub (
        .a  (op_a_q),
        .b  (op_b_q),
        .M  (op_m_q),
        .s  (sum_s),
        .co (sum_co)
    );

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_s     = rsp_s_q;
    assign bus.rsp_co    = rsp_co_q;
endmodule

// File: tb/tb_add_sub_arbiter.sv
// tb_add_sub_arbiter
//   Directed bench for add_sub_arbiter: reset, add/sub/wrap results,
//   round-robin under contention, back-pressure and reset mid-operation.
module tb_add_sub_arbiter;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    add_sub_arbiter_if #(.WIDTH(16)) bus ();

    add_sub_arbiter #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req0(input logic v, input logic [15:0] a, input logic [15:0] b, input logic m);
        bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_m = m;
    endtask

    task automatic set_req1(input logic v, input logic [15:0] a, input logic [15:0] b, input logic m);
        bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_m = m;
    endtask

    task automatic chk_rsp(input string tag, input logic id, input logic [15:0] s, input logic co);
        chk({tag, "_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        chk({tag, "_id"},    {31'd0, bus.rsp_id},    {31'd0, id});
        chk({tag, "_s"},     {16'd0, bus.rsp_s},     {16'd0, s});
        chk({tag, "_co"},    {31'd0, bus.rsp_co},    {31'd0, co});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        set_req0(1'b1, 16'd0, 16'd0, 1'b0);
        set_req1(1'b0, 16'd0, 16'd0, 1'b0);
        bus.rsp_ready = 1'b1;

        // Reset state: everything zero, ready low even with a valid request
        tick();
        tick();
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_s",     {16'd0, bus.rsp_s},     32'd0);
        chk("rst_rsp_co",    {31'd0, bus.rsp_co},    32'd0);
        chk("rst_rsp_id",    {31'd0, bus.rsp_id},    32'd0);
        chk("rst_ready0",    {31'd0, bus.req0_ready}, 32'd0);
        chk("rst_ready1",    {31'd0, bus.req1_ready}, 32'd0);

        // Contention right after reset: req0, req1, req0
        set_req0(1'b1, 16'd205, 16'd200, 1'b0);
        set_req1(1'b1, 16'd58,  16'd92,  1'b1);
        rst = 1'b0;
        #1;
        chk("rr1_ready0", {31'd0, bus.req0_ready}, 32'd1);
        chk("rr1_ready1", {31'd0, bus.req1_ready}, 32'd0);
        tick();
        tick();
        chk_rsp("rr1", 1'b0, 16'd405, 1'b0);
        tick();
        chk("rr2_ready0", {31'd0, bus.req0_ready}, 32'd0);
        chk("rr2_ready1", {31'd0, bus.req1_ready}, 32'd1);
        tick();
        tick();
        chk_rsp("rr2", 1'b1, 16'hFFDE, 1'b0);
        tick();
        chk("rr3_ready0", {31'd0, bus.req0_ready}, 32'd1);
        chk("rr3_ready1", {31'd0, bus.req1_ready}, 32'd0);
        tick();
        set_req0(1'b0, 16'd0, 16'd0, 1'b0);
        set_req1(1'b0, 16'd0, 16'd0, 1'b0);
        tick();
        chk_rsp("rr3", 1'b0, 16'd405, 1'b0);
        tick();
        chk("rr3_done", {31'd0, bus.rsp_valid}, 32'd0);

        // Subtraction on req1: 1-2 borrows, 5-2 does not
        set_req1(1'b1, 16'd1, 16'd2, 1'b1);
        #1;
        chk("sub1_ready1", {31'd0, bus.req1_ready}, 32'd1);
        tick();
        set_req1(1'b0, 16'hAAAA, 16'h5555, 1'b0);
        tick();
        chk_rsp("sub1", 1'b1, 16'hFFFF, 1'b0);
        tick();
        set_req1(1'b1, 16'd5, 16'd2, 1'b1);
        tick();
        set_req1(1'b0, 16'd0, 16'd0, 1'b0);
        tick();
        chk_rsp("sub2", 1'b1, 16'd3, 1'b1);
        tick();

        // Single req0 5+2, latency and operand changes after handshake
        set_req0(1'b1, 16'd5, 16'd2, 1'b0);
        #1;
        chk("add_ready0", {31'd0, bus.req0_ready}, 32'd1);
        chk("add_ready1", {31'd0, bus.req1_ready}, 32'd0);
        tick();
        set_req0(1'b0, 16'h1111, 16'h2222, 1'b1);
        #1;
        chk("add_exec_valid",  {31'd0, bus.rsp_valid},  32'd0);
        chk("add_exec_ready0", {31'd0, bus.req0_ready}, 32'd0);
        tick();
        chk_rsp("add", 1'b0, 16'd7, 1'b0);
        tick();
        chk("add_done", {31'd0, bus.rsp_valid}, 32'd0);

        // Wrap: lone req0 wins although prio now points at req1
        set_req0(1'b1, 16'hFFFF, 16'd1, 1'b0);
        #1;
        chk("wrap_ready0", {31'd0, bus.req0_ready}, 32'd1);
        tick();
        set_req0(1'b0, 16'd0, 16'd0, 1'b0);
        tick();
        chk_rsp("wrap", 1'b0, 16'd0, 1'b1);
        tick();

        // Back-pressure: 5 cycles of rsp_ready low, req0 waits meanwhile
        bus.rsp_ready = 1'b0;
        set_req1(1'b1, 16'h1234, 16'h0F0F, 1'b0);
        tick();
        set_req1(1'b0, 16'd0, 16'd0, 1'b0);
        set_req0(1'b1, 16'd10, 16'd3, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk_rsp("bp_hold", 1'b1, 16'h2143, 1'b0);
            chk("bp_ready0", {31'd0, bus.req0_ready}, 32'd0);
            chk("bp_ready1", {31'd0, bus.req1_ready}, 32'd0);
            if (i < 4) tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("bp_released", {31'd0, bus.rsp_valid}, 32'd0);
        chk("bp_wait_ready0", {31'd0, bus.req0_ready}, 32'd1);
        tick();
        set_req0(1'b0, 16'd0, 16'd0, 1'b0);
        tick();
        chk_rsp("bp_next", 1'b0, 16'd7, 1'b1);
        tick();

        // Reset during EXEC discards the operation
        set_req0(1'b1, 16'd100, 16'd1, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        chk("rexec_valid",  {31'd0, bus.rsp_valid},  32'd0);
        chk("rexec_s",      {16'd0, bus.rsp_s},      32'd0);
        chk("rexec_co",     {31'd0, bus.rsp_co},     32'd0);
        chk("rexec_ready0", {31'd0, bus.req0_ready}, 32'd0);
        tick();
        tick();
        set_req0(1'b0, 16'd0, 16'd0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rexec_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        end
        set_req0(1'b1, 16'd3, 16'd4, 1'b0);
        set_req1(1'b1, 16'd9, 16'd9, 1'b1);
        #1;
        chk("rexec_ready0_pref", {31'd0, bus.req0_ready}, 32'd1);
        chk("rexec_ready1_pref", {31'd0, bus.req1_ready}, 32'd0);
        tick();
        set_req0(1'b0, 16'd0, 16'd0, 1'b0);
        set_req1(1'b0, 16'd0, 16'd0, 1'b0);
        tick();
        chk_rsp("rexec_next", 1'b0, 16'd7, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/add_sub_arbiter.md
ADD_SUB_ARBITER -- requirements
Module: add_sub_arbiter

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width; all datapath ports below are WIDTH bits.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: req0_valid  input  1  requester 0 has an operation pending.
REQ-005 Port: req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 Port: req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-007 Port: req0_m  input  1  requester 0 mode: 0 = a+b, 1 = a-b.
REQ-008 Port: req1_valid, req1_ready, req1_a, req1_b, req1_m  same directions/widths/meanings as requester 0, for requester 1.
REQ-009 Port: rsp_valid  output  1  result available.
REQ-010 Port: rsp_ready  input  1  consumer accepts result.
REQ-011 Port: rsp_id  output  1  index of requester owning the result.
REQ-012 Port: rsp_s  output  WIDTH  sum/difference.
REQ-013 Port: rsp_co  output  1  carry out of the add_sub datapath.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, RESP; reset state IDLE.
REQ-015 IDLE: if any reqN_valid, SHALL grant one requester, assert its reqN_ready for exactly that cycle (combinational from state, valids, priority), latch a, b, m and id, go to EXEC; else stay IDLE.
REQ-016 reqN_ready SHALL be 0 in EXEC and RESP; at most one ready high in any cycle.
REQ-017 Arbitration SHALL be round-robin: pointer prio (reset 0) names the preferred requester; if only one valid, it wins regardless of prio.
REQ-018 prio SHALL flip to the non-granted requester on every grant.
REQ-019 EXEC: latched operands drive the shared add_sub datapath; result s and co SHALL be registered at end of EXEC; go to RESP.
REQ-020 RESP: rsp_valid SHALL be 1 with stable rsp_id, rsp_s, rsp_co until rsp_valid && rsp_ready; on that edge go to IDLE.
REQ-021 Latency: handshake at edge T SHALL yield rsp_valid at edge T+2; max throughput one operation per 3 cycles with rsp_ready held high.
REQ-022 m=0: rsp_s = (a+b) mod 2^WIDTH, rsp_co = carry out of bit WIDTH-1.
REQ-023 m=1: rsp_s = (a + ~b + 1) mod 2^WIDTH, rsp_co = carry out of that sum (1 = no borrow, a >= b unsigned).
REQ-024 A requester dropping valid or changing operands after its handshake SHALL NOT affect the in-flight result.
REQ-025 Requests arriving while in EXEC/RESP SHALL wait (ready low) and be arbitrated on return to IDLE.

Reset
REQ-026 On rst high, immediately: state IDLE, prio 0, rsp_valid 0, rsp_id 0, rsp_s 0, rsp_co 0, both ready 0, latched operands 0.
REQ-027 Reset mid-EXEC or mid-RESP SHALL discard the in-flight operation with no response emitted.

Structure
REQ-028 Shared package SHALL hold the FSM state encoding (IDLE/EXEC/RESP, 2 bits) and default WIDTH constant 16.
REQ-029 Datapath SHALL be one instance of the existing add_sub sub-module (ports a, b, M, s, co); no second adder.

Verification
REQ-030 Single req0: a=5, b=2, m=0 -> rsp_valid 2 cycles after handshake, rsp_id 0, rsp_s 7, rsp_co 0.
REQ-031 Subtraction: req1 a=1, b=2, m=1 -> rsp_s 0xFFFF, rsp_co 0; a=5, b=2, m=1 -> rsp_s 3, rsp_co 1.
REQ-032 Wrap: a=0xFFFF, b=1, m=0 -> rsp_s 0, rsp_co 1.
REQ-033 Both valid continuously after reset (req0 205+200, req1 58-92) -> req0 first (rsp_s 405, co 0), then req1 (rsp_s 0xFFDE, co 0), then req0 again.
REQ-034 Back-pressure: rsp_ready low 5 cycles in RESP -> rsp_valid/data held stable, both ready low; completes when rsp_ready rises.
REQ-035 rst asserted during EXEC -> outputs zero immediately, no rsp_valid afterwards; next request served normally with req0 preferred.
